// File: rtl/lif_run_sequencer.sv
`default_nettype none
// ============================================================================
// lif_run_sequencer : host command sequencer for one LIF neuron datapath
// Revision 1.0 : initial release
// ============================================================================
module lif_run_sequencer #(
    parameter int N_STAGES      = 5,
    parameter int COUNT_BITS    = 8,
    parameter int SPIKE_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [7:0]            cmd_data,
    input  logic                  abort,
    output logic [7:0]            load_data,
    output logic                  load_inputs,
    output logic                  load_weights,
    output logic                  execute,
    input  logic                  spike_in,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [COUNT_BITS-1:0] res_count,
    output logic                  res_err,
    output logic                  busy
);

    localparam int INPUTS = 2 ** N_STAGES;
    localparam int BYTES  = (INPUTS / 8 > 1) ? INPUTS / 8 : 1;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0]      LAST_BYTE  = CNT_W'(BYTES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX  = '1;
    localparam logic [1:0]            DRAIN_INIT = 2'((SPIKE_LATENCY > 0) ? SPIKE_LATENCY - 1 : 0);

    localparam logic [1:0] OP_LOAD_IN = 2'b00;
    localparam logic [1:0] OP_LOAD_WT = 2'b01;
    localparam logic [1:0] OP_RUN     = 2'b10;
    localparam logic [1:0] OP_CLEAR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_DRAIN  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [7:0]              load_data_q, load_data_d;
    logic                    load_inputs_q, load_inputs_d;
    logic                    load_weights_q, load_weights_d;
    logic                    execute_q, execute_d;
    logic [COUNT_BITS-1:0]   count_q, count_d;
    logic                    err_q, err_d;
    logic [CNT_W-1:0]        in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0]        wt_cnt_q, wt_cnt_d;
    logic                    inputs_loaded_q, inputs_loaded_d;
    logic                    weights_loaded_q, weights_loaded_d;
    logic [7:0]              t_rem_q, t_rem_d;
    logic [1:0]              drain_q, drain_d;

    logic                    abort_hit;
    logic                    sample_mark;

    assign abort_hit = abort && (state_q != S_IDLE);

    // Marks the cycle in which spike_in belongs to an execute-high timestep.
    generate
        if (SPIKE_LATENCY == 0) begin : g_no_delay
            assign sample_mark = execute_q;
        end else begin : g_delay
            logic [SPIKE_LATENCY-1:0] exec_dly_q;
            always_ff @(posedge clk) begin
                if (reset || abort_hit) begin
                    exec_dly_q <= '0;
                end else begin
                    exec_dly_q[0] <= execute_q;
                    for (int i = 1; i < SPIKE_LATENCY; i++) begin
                        exec_dly_q[i] <= exec_dly_q[i-1];
                    end
                end
            end
            assign sample_mark = exec_dly_q[SPIKE_LATENCY-1];
        end
    endgenerate

    always_comb begin
        state_d          = state_q;
        load_data_d      = load_data_q;
        load_inputs_d    = 1'b0;
        load_weights_d   = 1'b0;
        execute_d        = 1'b0;
        count_d          = count_q;
        err_d            = err_q;
        in_cnt_d         = in_cnt_q;
        wt_cnt_d         = wt_cnt_q;
        inputs_loaded_d  = inputs_loaded_q;
        weights_loaded_d = weights_loaded_q;
        t_rem_d          = t_rem_q;
        drain_d          = drain_q;

        if ((state_q == S_RUN || state_q == S_DRAIN) && sample_mark && spike_in
            && (count_q != COUNT_MAX)) begin
            count_d = count_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD_IN: begin
                            load_data_d   = cmd_data;
                            load_inputs_d = 1'b1;
                            if (in_cnt_q == LAST_BYTE) begin
                                in_cnt_d        = '0;
                                inputs_loaded_d = 1'b1;
                            end else begin
                                in_cnt_d = in_cnt_q + 1'b1;
                            end
                        end
                        OP_LOAD_WT: begin
                            load_data_d    = cmd_data;
                            load_weights_d = 1'b1;
                            if (wt_cnt_q == LAST_BYTE) begin
                                wt_cnt_d         = '0;
                                weights_loaded_d = 1'b1;
                            end else begin
                                wt_cnt_d = wt_cnt_q + 1'b1;
                            end
                        end
                        OP_CLEAR: begin
                            in_cnt_d        = '0;
                            wt_cnt_d        = '0;
                            inputs_loaded_d = 1'b0;
                        end
                        OP_RUN: begin
                            count_d = '0;
                            // A partially shifted byte stream leaves the neuron in an undefined state.
                            if (!inputs_loaded_q || !weights_loaded_q
                                || (in_cnt_q != '0) || (wt_cnt_q != '0)) begin
                                err_d   = 1'b1;
                                state_d = S_REPORT;
                            end else if (cmd_data == 8'd0) begin
                                err_d   = 1'b0;
                                state_d = S_REPORT;
                            end else begin
                                err_d     = 1'b0;
                                execute_d = 1'b1;
                                t_rem_d   = cmd_data - 8'd1;
                                state_d   = S_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (t_rem_q == 8'd0) begin
                    if (SPIKE_LATENCY == 0) begin
                        state_d = S_REPORT;
                    end else begin
                        drain_d = DRAIN_INIT;
                        state_d = S_DRAIN;
                    end
                end else begin
                    t_rem_d   = t_rem_q - 8'd1;
                    execute_d = 1'b1;
                end
            end
            S_DRAIN: begin
                if (drain_q == 2'd0) begin
                    state_d = S_REPORT;
                end else begin
                    drain_d = drain_q - 2'd1;
                end
            end
            S_REPORT: begin
                if (res_ready) begin
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort drops any run or pending result; loaded flags survive.
        if (abort_hit) begin
            state_d   = S_IDLE;
            execute_d = 1'b0;
            count_d   = '0;
            err_d     = 1'b0;
            t_rem_d   = 8'd0;
            drain_d   = 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            load_data_q      <= 8'd0;
            load_inputs_q    <= 1'b0;
            load_weights_q   <= 1'b0;
            execute_q        <= 1'b0;
            count_q          <= '0;
            err_q            <= 1'b0;
            in_cnt_q         <= '0;
            wt_cnt_q         <= '0;
            inputs_loaded_q  <= 1'b0;
            weights_loaded_q <= 1'b1;
            t_rem_q          <= 8'd0;
            drain_q          <= 2'd0;
        end else begin
            state_q          <= state_d;
            load_data_q      <= load_data_d;
            load_inputs_q    <= load_inputs_d;
            load_weights_q   <= load_weights_d;
            execute_q        <= execute_d;
            count_q          <= count_d;
            err_q            <= err_d;
            in_cnt_q         <= in_cnt_d;
            wt_cnt_q         <= wt_cnt_d;
            inputs_loaded_q  <= inputs_loaded_d;
            weights_loaded_q <= weights_loaded_d;
            t_rem_q          <= t_rem_d;
            drain_q          <= drain_d;
        end
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign res_valid    = (state_q == S_REPORT);
    assign res_count    = count_q;
    assign res_err      = err_q;
    assign load_data    = load_data_q;
    assign load_inputs  = load_inputs_q;
    assign load_weights = load_weights_q;
    assign execute      = execute_q;

endmodule
`default_nettype wire

// File: tb/tb_lif_run_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lif_run_sequencer : directed vector bench for lif_run_sequencer
// Revision 1.0 : initial release
// ============================================================================
module tb_lif_run_sequencer;

    localparam int CB = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'd0;
    logic [7:0]    cmd_data = 8'd0;
    logic          abort = 1'b0;
    logic          spike_in = 1'b0;
    logic          res_ready = 1'b0;
    logic          cmd_ready, load_inputs, load_weights, execute, res_valid, res_err, busy;
    logic [7:0]    load_data;
    logic [CB-1:0] res_count;

    lif_run_sequencer #(
        .N_STAGES     (5),
        .COUNT_BITS   (CB),
        .SPIKE_LATENCY(1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .abort       (abort),
        .load_data   (load_data),
        .load_inputs (load_inputs),
        .load_weights(load_weights),
        .execute     (execute),
        .spike_in    (spike_in),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_count   (res_count),
        .res_err     (res_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       cv;
        logic [1:0] op;
        logic [7:0] d;
        logic       ab;
        logic       sp;
        logic       rr;
    } ins_t;

    typedef struct packed {
        logic          cr;
        logic [7:0]    ld;
        logic          li;
        logic          lw;
        logic          ex;
        logic          rv;
        logic [CB-1:0] rc;
        logic          re;
        logic          bz;
    } outs_t;

    typedef struct packed {
        ins_t  i;
        outs_t o;
    } vec_t;

    vec_t vecs [20];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic ins_t mk_in(input logic cv, input logic [1:0] op, input logic [7:0] d,
                                   input logic ab, input logic sp, input logic rr);
        return {cv, op, d, ab, sp, rr};
    endfunction

    function automatic outs_t mk_out(input logic cr, input logic [7:0] ld, input logic li,
                                     input logic lw, input logic ex, input logic rv,
                                     input logic [CB-1:0] rc, input logic re, input logic bz);
        return {cr, ld, li, lw, ex, rv, rc, re, bz};
    endfunction

    function automatic outs_t sample_outs();
        return {cmd_ready, load_data, load_inputs, load_weights, execute, res_valid,
                res_count, res_err, busy};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, observe 1ns later (registered outputs are stable).
    task automatic step(input ins_t v);
        @(negedge clk);
        cmd_valid = v.cv;
        cmd_op    = v.op;
        cmd_data  = v.d;
        abort     = v.ab;
        spike_in  = v.sp;
        res_ready = v.rr;
        #1;
    endtask

    task automatic idle_step();
        step(mk_in(0, 2'd0, 8'd0, 0, 0, 0));
    endtask

    task automatic issue(input logic [1:0] op, input logic [7:0] d);
        step(mk_in(1, op, d, 0, 0, 0));
    endtask

    task automatic expect_report(input string name, input logic err, input logic [CB-1:0] cnt);
        bit seen = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            idle_step();
            seen = res_valid;
        end
        chk({name, "_valid"}, seen, 1);
        chk({name, "_err"}, res_err, err);
        chk({name, "_count"}, res_count, cnt);
        step(mk_in(0, 2'd0, 8'd0, 0, 0, 1));
        idle_step();
        chk({name, "_idle"}, {busy, res_valid, cmd_ready}, 3'b001);
    endtask

    // smask[j-1] is spike_in in cycle j after acceptance; bit k is the sample of timestep k.
    task automatic run_seq(input string name, input int t, input logic [255:0] smask,
                           input logic [CB-1:0] exp_cnt, input int hold);
        int ex_n    = 0;
        bit clash   = 0;
        bit unstable = 0;
        step(mk_in(1, 2'd2, 8'(t), 0, 0, 0));
        chk({name, "_accept"}, cmd_ready, 1);
        if (execute) ex_n++;
        for (int j = 1; j <= t + 1; j++) begin
            step(mk_in(0, 2'd0, 8'd0, 0, smask[j-1], 0));
            if (execute) ex_n++;
            if (execute && (load_inputs || load_weights)) clash = 1;
        end
        chk({name, "_exec_cycles"}, ex_n, t);
        chk({name, "_no_clash"}, clash, 0);
        step(mk_in(0, 2'd0, 8'd0, 0, 1, 0));
        chk({name, "_report"}, {res_valid, res_count, res_err}, {1'b1, exp_cnt, 1'b0});
        for (int k = 0; k < hold; k++) begin
            step(mk_in(0, 2'd0, 8'd0, 0, 1, 0));
            if (!res_valid || res_count !== exp_cnt || res_err !== 1'b0) unstable = 1;
        end
        if (hold > 0) chk({name, "_stable"}, unstable, 0);
        step(mk_in(0, 2'd0, 8'd0, 0, 0, 1));
        idle_step();
        chk({name, "_done"}, {busy, res_valid, cmd_ready}, 3'b001);
    endtask

    initial begin
        logic [255:0] m;

        // Run refused without loads, four input loads, four weight loads, then T=2.
        vecs[0]  = '{mk_in(1, 2'd2, 8'd4,  0, 0, 0), mk_out(1, 8'h00, 0, 0, 0, 0, 4'd0, 0, 0)};
        vecs[1]  = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(0, 8'h00, 0, 0, 0, 1, 4'd0, 1, 1)};
        vecs[2]  = '{mk_in(0, 2'd0, 8'd0,  0, 0, 1), mk_out(0, 8'h00, 0, 0, 0, 1, 4'd0, 1, 1)};
        vecs[3]  = '{mk_in(1, 2'd0, 8'hFF, 0, 0, 0), mk_out(1, 8'h00, 0, 0, 0, 0, 4'd0, 0, 0)};
        vecs[4]  = '{mk_in(1, 2'd0, 8'hFF, 0, 0, 0), mk_out(1, 8'hFF, 1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[5]  = '{mk_in(1, 2'd0, 8'hFF, 0, 0, 0), mk_out(1, 8'hFF, 1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[6]  = '{mk_in(1, 2'd0, 8'hFF, 0, 0, 0), mk_out(1, 8'hFF, 1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[7]  = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(1, 8'hFF, 1, 0, 0, 0, 4'd0, 0, 0)};
        vecs[8]  = '{mk_in(1, 2'd1, 8'h01, 1, 0, 0), mk_out(1, 8'hFF, 0, 0, 0, 0, 4'd0, 0, 0)};
        vecs[9]  = '{mk_in(1, 2'd1, 8'h02, 0, 0, 0), mk_out(1, 8'h01, 0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[10] = '{mk_in(1, 2'd1, 8'h03, 0, 0, 0), mk_out(1, 8'h02, 0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[11] = '{mk_in(1, 2'd1, 8'h04, 0, 0, 0), mk_out(1, 8'h03, 0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[12] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(1, 8'h04, 0, 1, 0, 0, 4'd0, 0, 0)};
        vecs[13] = '{mk_in(1, 2'd2, 8'd2,  0, 0, 0), mk_out(1, 8'h04, 0, 0, 0, 0, 4'd0, 0, 0)};
        vecs[14] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(0, 8'h04, 0, 0, 1, 0, 4'd0, 0, 1)};
        vecs[15] = '{mk_in(0, 2'd0, 8'd0,  0, 1, 0), mk_out(0, 8'h04, 0, 0, 1, 0, 4'd0, 0, 1)};
        vecs[16] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(0, 8'h04, 0, 0, 0, 0, 4'd1, 0, 1)};
        vecs[17] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(0, 8'h04, 0, 0, 0, 1, 4'd1, 0, 1)};
        vecs[18] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 1), mk_out(0, 8'h04, 0, 0, 0, 1, 4'd1, 0, 1)};
        vecs[19] = '{mk_in(0, 2'd0, 8'd0,  0, 0, 0), mk_out(1, 8'h04, 0, 0, 0, 0, 4'd0, 0, 0)};

        repeat (2) @(negedge clk);
        #1;
        chk("reset_state", sample_outs(), mk_out(1, 8'h00, 0, 0, 0, 0, 4'd0, 0, 0));
        reset = 1'b0;

        for (int k = 0; k < 20; k++) begin
            step(vecs[k].i);
            chk($sformatf("vec%0d", k), sample_outs(), vecs[k].o);
        end

        // T=10: marked spikes on timesteps 2, 5, 9; bit 0 lands in an unmarked cycle.
        m = '0;
        m[0] = 1'b1; m[2] = 1'b1; m[5] = 1'b1; m[9] = 1'b1;
        run_seq("run10", 10, m, 4'd3, 0);

        // Saturation with a held report.
        run_seq("sat255", 255, {256{1'b1}}, 4'd15, 5);

        // Abort on the third execute cycle of a T=20 run.
        issue(2'd2, 8'd20);
        idle_step();
        idle_step();
        step(mk_in(0, 2'd0, 8'd0, 1, 0, 0));
        chk("abort_exec_before", execute, 1);
        idle_step();
        chk("abort_after", {execute, res_valid, cmd_ready, busy, res_count}, {4'b0010, 4'd0});
        begin
            bit rv_seen = 0;
            for (int k = 0; k < 4; k++) begin
                idle_step();
                if (res_valid) rv_seen = 1;
            end
            chk("abort_no_result", rv_seen, 0);
        end
        m = '0;
        m[1] = 1'b1;
        run_seq("post_abort", 2, m, 4'd1, 0);

        // Partial input load refuses the run; clear drops inputs_loaded.
        issue(2'd0, 8'hAA);
        issue(2'd0, 8'h55);
        issue(2'd2, 8'd3);
        expect_report("partial", 1, 4'd0);
        issue(2'd3, 8'd0);
        issue(2'd2, 8'd1);
        expect_report("cleared", 1, 4'd0);
        for (int k = 0; k < 4; k++) issue(2'd0, 8'h3C);
        run_seq("reload", 1, m, 4'd1, 0);

        // Zero-timestep run reports immediately without error.
        issue(2'd2, 8'd0);
        expect_report("t_zero", 0, 4'd0);

        // Reset during a run.
        issue(2'd2, 8'd20);
        idle_step();
        reset = 1'b1;
        idle_step();
        chk("reset_mid_run", sample_outs(), mk_out(1, 8'h00, 0, 0, 0, 0, 4'd0, 0, 0));
        reset = 1'b0;
        issue(2'd2, 8'd1);
        expect_report("after_reset", 1, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lif_run_sequencer.md
Name: lif_run_sequencer

Overview:
- Host-facing sequencer for one LIF neuron datapath (input/weight shift registers, `execute` enable, `spike` output).
- Accepts byte commands over a valid/ready port and streams input and weight bytes into the neuron's load shift registers.
- Runs the neuron for a commanded number of timesteps while counting output spikes, then returns a spike-count result over a second valid/ready port.
- Replaces the direct pin-level `execute`/`setup_control` drive at the top level.

Parameters:
- N_STAGES, 5, neuron size exponent; synapse count INPUTS = 2**N_STAGES; bytes per load BYTES = INPUTS/8 (min 1).
- COUNT_BITS, 8, width of the spike counter.
- SPIKE_LATENCY, 1, cycles from an `execute`-high cycle to the `spike_in` for that timestep (0..3).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when valid & ready
- cmd_op  in  2  00 load-input byte, 01 load-weight byte, 10 run, 11 clear-load-state
- cmd_data  in  8  load byte, or timestep count T for run
- abort  in  1  single-cycle abort of run/report
- load_data  out  8  byte to neuron shift registers
- load_inputs  out  1  one-cycle strobe: shift load_data into inputs
- load_weights  out  1  one-cycle strobe: shift load_data into weights
- execute  out  1  neuron enable
- spike_in  in  1  neuron spike output
- res_valid  out  1  result available
- res_ready  in  1  result consumed when valid & ready
- res_count  out  COUNT_BITS  spikes counted in the run
- res_err  out  1  run refused because inputs were not loaded
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, RUN, DRAIN, REPORT.
- Reset values: state IDLE, cmd_ready 1, all strobes 0, execute 0, res_valid 0, res_count 0, res_err 0, load_data 0, in_cnt 0, wt_cnt 0, inputs_loaded 0, weights_loaded 1 (neuron resets weights to all +1).
- Reset wins over every other input in the same cycle, including mid-run and mid-report.
- cmd_ready = 1 only in IDLE. Commands are never accepted outside IDLE.
- Load (op 00/01) accepted in IDLE:
  - Next cycle: load_data = cmd_data and the matching strobe is high for exactly one cycle (latency 1).
  - Back-to-back loads are allowed, one per cycle.
  - The byte counter (in_cnt or wt_cnt) increments mod BYTES. When it wraps from BYTES-1, the corresponding loaded flag sets and stays set.
  - Strobes and execute are never high together.
- Clear (op 11) in IDLE: in_cnt = wt_cnt = 0, inputs_loaded = 0. weights_loaded is unchanged. No strobes.
- Run (op 10) in IDLE:
  - If inputs_loaded = 0, or in_cnt ≠ 0, or wt_cnt ≠ 0: go to REPORT next cycle with res_err = 1, res_count = 0. No execute.
  - If T = 0: go to REPORT with res_err = 0, res_count = 0.
  - Otherwise: clear the counter, enter RUN, and drive execute high for exactly T consecutive cycles, starting the cycle after acceptance.
- Spike sampling:
  - An execute delay line of depth SPIKE_LATENCY marks sample cycles.
  - On each marked cycle, spike_in = 1 increments the counter, saturating at 2**COUNT_BITS-1.
  - spike_in outside marked cycles is ignored.
- RUN→DRAIN after the T-th execute cycle. DRAIN lasts SPIKE_LATENCY cycles. If SPIKE_LATENCY = 0, go RUN→REPORT directly.
- REPORT:
  - res_valid = 1; res_count and res_err are held stable until the res_valid & res_ready cycle.
  - Next cycle: IDLE, res_valid = 0.
  - res_ready while res_valid = 0 is ignored.
- Abort (any state except IDLE) returns to IDLE next cycle:
  - execute = 0 and res_valid = 0 in that next cycle, counter cleared, no result produced.
  - Loaded flags are kept.
  - If abort and res_ready arrive in the same REPORT cycle, the result counts as consumed; outcome identical.
- Abort in IDLE has no effect. A command presented in the same cycle as abort is accepted normally.

Test Plan:
- Reset, then run T = 4 with no loads → no execute pulse; REPORT with res_err = 1, res_count = 0; busy returns 0 after the handshake.
- Load input bytes 0xFF ×4 (N_STAGES = 5), one per cycle → load_inputs high 4 consecutive cycles, each one cycle after acceptance, load_data matching each byte; inputs_loaded = 1.
- After the loads, run T = 10 with spike_in = 1 on the sample cycles of timesteps 2, 5 and 9 only, plus a spike_in = 1 outside the window → execute high exactly 10 cycles; res_count = 3, res_err = 0.
- Run T = 255 with COUNT_BITS = 4 and spike_in held 1 → res_count saturates at 15; res_valid held with res_ready low for 5 cycles, values stable.
- Abort on the 3rd execute cycle of a T = 20 run → execute low the next cycle, no res_valid, cmd_ready = 1; a subsequent run T = 2 works with inputs_loaded still set.
- Load 2 input bytes, then run → res_err = 1. Then clear, then 4 input loads, then run T = 1 → res_err = 0. Reset asserted during RUN → all outputs at reset values next cycle.
